// File: rtl/ppfifo_stream_writer_pkg.sv
// Shared definitions for the ping-pong FIFO stream writer and reader.
// State encodings and count width are common to both sides.
package ppfifo_stream_writer_pkg;

    localparam int CNT_W = 24;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2
    } pp_state_t;

    // Both buffers free: take the one not released last, so buffers alternate.
    function automatic logic pick_buf(
        input logic [1:0] ready,
        input logic       last_buf
    );
        if (ready == 2'b11) begin
            return ~last_buf;
        end
        return ready[1];
    endfunction

endpackage

// File: rtl/ppfifo_stream_writer.sv
// Feeds a valid/ready word stream into the ping-pong FIFO write port,
// claiming one buffer at a time and releasing it on last/full/timeout.
module ppfifo_stream_writer
    import ppfifo_stream_writer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [1:0]            write_ready,
    output logic [1:0]            write_activate,
    input  logic [23:0]           write_fifo_size,
    output logic                  write_strobe,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [31:0]           packets_written
);

    localparam cnt_t TIMEOUT    = cnt_t'(IDLE_TIMEOUT);
    localparam bit   TIMEOUT_EN = (IDLE_TIMEOUT != 0);

    pp_state_t             state, state_n;
    cnt_t                  count, count_n;
    cnt_t                  idle, idle_n;
    logic                  last_buf, last_buf_n;
    logic [1:0]            act_n;
    logic                  strobe_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [31:0]           pkts_n;

    logic                  sel;
    logic                  accept;
    cnt_t                  count_inc;
    cnt_t                  idle_inc;

    assign in_ready  = (state == ST_ACTIVE) && (count < write_fifo_size);
    assign accept    = in_valid && in_ready;
    assign count_inc = count + cnt_t'(1);
    assign idle_inc  = (idle == '1) ? idle : idle + cnt_t'(1);
    assign sel       = pick_buf(write_ready, last_buf);

    always_comb begin
        state_n    = state;
        count_n    = count;
        idle_n     = idle;
        last_buf_n = last_buf;
        act_n      = write_activate;
        strobe_n   = 1'b0;
        data_n     = write_data;
        pkts_n     = packets_written;
        unique case (state)
            ST_IDLE: begin
                if (write_fifo_size != '0 && write_ready != 2'b00) begin
                    act_n   = sel ? 2'b10 : 2'b01;
                    count_n = '0;
                    idle_n  = '0;
                    state_n = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    count_n  = count_inc;
                    data_n   = in_data;
                    strobe_n = 1'b1;
                    idle_n   = '0;
                    // last and full together still give a single release
                    if (in_last || count_inc == write_fifo_size) begin
                        state_n = ST_RELEASE;
                    end
                end else if (count != '0) begin
                    idle_n = idle_inc;
                    if (TIMEOUT_EN && idle_inc == TIMEOUT) begin
                        state_n = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                act_n      = 2'b00;
                last_buf_n = write_activate[1];
                pkts_n     = packets_written + 32'd1;
                state_n    = ST_IDLE;
            end
            default: begin
                act_n   = 2'b00;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            count           <= '0;
            idle            <= '0;
            last_buf        <= 1'b1;
            write_activate  <= 2'b00;
            write_strobe    <= 1'b0;
            write_data      <= '0;
            packets_written <= '0;
        end else begin
            state           <= state_n;
            count           <= count_n;
            idle            <= idle_n;
            last_buf        <= last_buf_n;
            write_activate  <= act_n;
            write_strobe    <= strobe_n;
            write_data      <= data_n;
            packets_written <= pkts_n;
        end
    end

endmodule

// File: tb/tb_ppfifo_stream_writer.sv
// Directed bench for ppfifo_stream_writer; a second instance has the
// idle timeout disabled and shares all inputs.
module tb_ppfifo_stream_writer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [1:0]    write_ready = 2'b00;
    logic [23:0]   write_fifo_size = 24'd16;

    logic          in_ready;
    logic [1:0]    act;
    logic          strobe;
    logic [DW-1:0] wdata;
    logic [31:0]   pkts;

    logic          nt_in_ready;
    logic [1:0]    nt_act;
    logic          nt_strobe;
    logic [DW-1:0] nt_wdata;
    logic [31:0]   nt_pkts;

    int checks = 0;
    int errors = 0;

    ppfifo_stream_writer #(.DATA_WIDTH(DW), .IDLE_TIMEOUT(10)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last),
        .write_ready(write_ready), .write_activate(act),
        .write_fifo_size(write_fifo_size),
        .write_strobe(strobe), .write_data(wdata),
        .packets_written(pkts)
    );

    ppfifo_stream_writer #(.DATA_WIDTH(DW), .IDLE_TIMEOUT(0)) dut_nt (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid),
        .in_ready(nt_in_ready), .in_last(in_last),
        .write_ready(write_ready), .write_activate(nt_act),
        .write_fifo_size(write_fifo_size),
        .write_strobe(nt_strobe), .write_data(nt_wdata),
        .packets_written(nt_pkts)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        write_ready = 2'b00;
        write_fifo_size = 24'd16;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({in_ready, act, strobe, wdata, pkts} !== '0) begin
            errors++;
            $display("FAIL reset: rdy=%b act=%b stb=%b data=%h pkts=%0d, required all zero",
                     in_ready, act, strobe, wdata, pkts);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_packet();
        do_reset();
        write_ready = 2'b11;
        tick();
        checks++;
        if ({act, in_ready} !== {2'b01, 1'b1}) begin
            errors++;
            $display("FAIL single_claim: act=%b rdy=%b, required 01 1", act, in_ready);
        end
        write_ready = 2'b00;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = DW'(8'h10 + i);
            in_last = (i == 4);
            tick();
            checks++;
            if ({strobe, wdata} !== {1'b1, DW'(8'h10 + i)}) begin
                errors++;
                $display("FAIL single_strobe%0d: stb=%b data=%h, required 1 %h",
                         i, strobe, wdata, DW'(8'h10 + i));
            end
        end
        checks++;
        if ({in_ready, act} !== {1'b0, 2'b01}) begin
            errors++;
            $display("FAIL single_release: rdy=%b act=%b, required 0 01", in_ready, act);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        tick();
        checks++;
        if ({act, strobe, pkts} !== {2'b00, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL single_done: act=%b stb=%b pkts=%0d, required 00 0 1",
                     act, strobe, pkts);
        end
    endtask

    task automatic test_continuous();
        int         w;
        int         exp_n[3];
        logic [1:0] exp_act[3];
        exp_n = '{16, 16, 8};
        exp_act = '{2'b01, 2'b10, 2'b01};
        do_reset();
        write_ready = 2'b11;
        w = 1;
        in_valid = 1'b1;
        in_data = DW'(w);
        in_last = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tick();
            checks++;
            if ({act, in_ready} !== {exp_act[b], 1'b1}) begin
                errors++;
                $display("FAIL cont_claim%0d: act=%b rdy=%b, required %b 1",
                         b, act, in_ready, exp_act[b]);
            end
            for (int k = 0; k < exp_n[b]; k++) begin
                tick();
                checks++;
                if ({strobe, wdata} !== {1'b1, DW'(w)}) begin
                    errors++;
                    $display("FAIL cont_word%0d: stb=%b data=%h, required 1 %h",
                             w, strobe, wdata, DW'(w));
                end
                w++;
                in_data = DW'(w);
                in_last = (w == 40);
            end
            checks++;
            if ({in_ready, act} !== {1'b0, exp_act[b]}) begin
                errors++;
                $display("FAIL cont_release%0d: rdy=%b act=%b, required 0 %b",
                         b, in_ready, act, exp_act[b]);
            end
            tick();
            checks++;
            if ({act, in_ready, strobe} !== 4'b0000) begin
                errors++;
                $display("FAIL cont_gap%0d: act=%b rdy=%b stb=%b, required 00 0 0",
                         b, act, in_ready, strobe);
            end
        end
        checks++;
        if (pkts !== 32'd3) begin
            errors++;
            $display("FAIL cont_pkts: pkts=%0d, required 3", pkts);
        end
        in_valid = 1'b0;
        write_ready = 2'b00;
    endtask

    task automatic test_timeout();
        do_reset();
        write_ready = 2'b11;
        tick();
        write_ready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = DW'(8'hA0 + i);
            tick();
        end
        in_valid = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j < 10) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_wait%0d: rdy=%b, required 1", j, in_ready);
                end
            end
        end
        checks++;
        if ({in_ready, act} !== {1'b0, 2'b01}) begin
            errors++;
            $display("FAIL tmo_release: rdy=%b act=%b, required 0 01", in_ready, act);
        end
        tick();
        checks++;
        if ({act, pkts} !== {2'b00, 32'd1}) begin
            errors++;
            $display("FAIL tmo_done: act=%b pkts=%0d, required 00 1", act, pkts);
        end
        checks++;
        if ({nt_act, nt_in_ready, nt_strobe, nt_wdata, nt_pkts}
            !== {2'b01, 1'b1, 1'b0, DW'(8'hA2), 32'd0}) begin
            errors++;
            $display("FAIL tmo_disabled: act=%b rdy=%b stb=%b data=%h pkts=%0d, required 01 1 0 a2 0",
                     nt_act, nt_in_ready, nt_strobe, nt_wdata, nt_pkts);
        end
        do_reset();
        write_ready = 2'b11;
        tick();
        write_ready = 2'b00;
        repeat (30) tick();
        checks++;
        if ({act, in_ready, pkts} !== {2'b01, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL tmo_empty: act=%b rdy=%b pkts=%0d, required 01 1 0",
                     act, in_ready, pkts);
        end
    endtask

    task automatic test_last_at_full();
        do_reset();
        write_ready = 2'b11;
        tick();
        write_ready = 2'b00;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            in_data = DW'(k);
            in_last = (k == 16);
            tick();
        end
        checks++;
        if ({in_ready, strobe, wdata} !== {1'b0, 1'b1, DW'(16)}) begin
            errors++;
            $display("FAIL full_last_release: rdy=%b stb=%b data=%h, required 0 1 10",
                     in_ready, strobe, wdata);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        tick();
        checks++;
        if ({act, pkts} !== {2'b00, 32'd1}) begin
            errors++;
            $display("FAIL full_last_done: act=%b pkts=%0d, required 00 1", act, pkts);
        end
        repeat (5) tick();
        checks++;
        if ({act, pkts} !== {2'b00, 32'd1}) begin
            errors++;
            $display("FAIL full_last_once: act=%b pkts=%0d, required 00 1", act, pkts);
        end
    endtask

    task automatic test_no_buffer();
        do_reset();
        in_valid = 1'b1;
        in_data = DW'(8'h55);
        for (int c = 0; c < 50; c++) begin
            tick();
            checks++;
            if ({in_ready, act} !== 3'b000) begin
                errors++;
                $display("FAIL nobuf_c%0d: rdy=%b act=%b, required 0 00", c, in_ready, act);
            end
        end
        in_valid = 1'b0;
        write_fifo_size = 24'd0;
        write_ready = 2'b11;
        repeat (5) tick();
        checks++;
        if (act !== 2'b00) begin
            errors++;
            $display("FAIL zero_size: act=%b, required 00", act);
        end
        write_fifo_size = 24'd16;
        write_ready = 2'b10;
        tick();
        checks++;
        if ({act, in_ready} !== {2'b10, 1'b1}) begin
            errors++;
            $display("FAIL nobuf_claim1: act=%b rdy=%b, required 10 1", act, in_ready);
        end
        write_ready = 2'b00;
    endtask

    task automatic test_async_reset();
        do_reset();
        write_ready = 2'b01;
        tick();
        write_ready = 2'b00;
        in_valid = 1'b1;
        in_last = 1'b1;
        in_data = DW'(8'h01);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        tick();
        write_ready = 2'b11;
        tick();
        checks++;
        if (act !== 2'b10) begin
            errors++;
            $display("FAIL alt_claim: act=%b, required 10", act);
        end
        write_ready = 2'b00;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data = DW'(8'h30 + k);
            tick();
        end
        checks++;
        if ({strobe, wdata} !== {1'b1, DW'(8'h36)}) begin
            errors++;
            $display("FAIL arst_pre: stb=%b data=%h, required 1 36", strobe, wdata);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({act, strobe, in_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL arst_async: act=%b stb=%b rdy=%b, required 00 0 0",
                     act, strobe, in_ready);
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        write_ready = 2'b11;
        tick();
        checks++;
        if ({act, pkts} !== {2'b01, 32'd0}) begin
            errors++;
            $display("FAIL arst_resume: act=%b pkts=%0d, required 01 0", act, pkts);
        end
        write_ready = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_packet();
        test_continuous();
        test_timeout();
        test_last_at_full();
        test_no_buffer();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppfifo_stream_writer.md
Name: ppfifo_stream_writer

Overview:
- Upstream feeder for the ping-pong FIFO write port.
- Accepts a valid/ready word stream with an end-of-packet flag.
- Claims an empty ping-pong buffer, streams words into it, then releases it for the read side.
- Release happens on packet end, buffer full, or input idle timeout.
- Runs entirely in the ping-pong FIFO's write clock domain.

Parameters:
DATA_WIDTH, 8, width of stream words and write_data
IDLE_TIMEOUT, 0, idle cycles with a partially filled buffer before forced release; 0 disables the timeout

Ports:
clk  input  1  write-side clock
rst  input  1  reset, asynchronous, active-high
in_data  input  DATA_WIDTH  stream word
in_valid  input  1  in_data valid
in_ready  output  1  block accepts a word this cycle
in_last  input  1  current word ends a packet
write_ready  input  2  per-buffer empty/available flags from the ping-pong FIFO
write_activate  output  2  one-hot buffer claim; 00 when no buffer is held
write_fifo_size  input  24  buffer capacity in words
write_strobe  output  1  write one word into the active buffer
write_data  output  DATA_WIDTH  word to write
packets_written  output  32  count of buffer releases, wraps at 2^32

Interface decision: one clock (clk); reset rst is asynchronous and active-high.

Behaviour:
- Reset values: in_ready=0, write_activate=00, write_strobe=0, write_data=0, packets_written=0.
- Internal reset values: state=IDLE, word count=0, idle counter=0, last_buf=1 (so buffer 0 is preferred first).
- Reset asserted mid-operation drops write_activate immediately (asynchronous). The partially written buffer is left to the FIFO's own reset.

FSM states: IDLE, ACTIVE, RELEASE.

IDLE:
- in_ready=0.
- Stays in IDLE if write_fifo_size==0 or write_ready==00.
- If exactly one write_ready bit is set: claim that buffer.
- If both bits are set: claim the buffer other than last_buf (alternation).
- On claim: write_activate <= one-hot of the chosen buffer, word count <= 0, idle counter <= 0, next state ACTIVE.
- Claim latency is one cycle after write_ready is sampled.

ACTIVE:
- in_ready = (count < write_fifo_size); combinational from the registered count.
- Accept condition: in_valid && in_ready.
  - On accept: count += 1; write_data <= in_data and write_strobe <= 1 in the next cycle (registered, 1-cycle latency); idle counter <= 0.
  - No accept: write_strobe <= 0; the idle counter increments only when count > 0.
- Transition to RELEASE, all cases forcing in_ready=0 from the next cycle:
  - (a) accepted word has in_last=1;
  - (b) the accept makes count == write_fifo_size;
  - (c) IDLE_TIMEOUT != 0 and the idle counter reaches IDLE_TIMEOUT with count > 0.
- If (a) and (b) occur together, only one release and one packets_written increment happen.
- An empty buffer (count==0) is never released by timeout; it is held until data arrives.

RELEASE:
- The final registered write_strobe, if any, issues in this cycle while write_activate is still set.
- Next cycle: write_activate <= 00, last_buf <= released buffer, packets_written += 1, state IDLE.
- write_activate is never changed in a cycle where write_strobe=1.
- write_strobe is asserted only while write_activate != 00.

Widths:
- Word count is 24 bits and compared against write_fifo_size.
- Idle counter is 24 bits and saturates.
- packets_written wraps to 0 after 0xFFFFFFFF.

Back-to-back packets:
- Minimum gap is 2 cycles (RELEASE, IDLE) between the last accept and the first accept into the next buffer.
- in_valid may remain high throughout that gap.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=0, ACTIVE=1, RELEASE=2) and the 24-bit count width constant, both reused by the read-side consumer.
- No sub-module needed. Claim arbitration and the FSM stay in one module.

Test Plan:
- Reset, then write_ready=11, size=16, stream 5 words ending in in_last -> write_activate=01 one cycle after ready; 5 write_strobes each one cycle after its accept; activate drops after the 5th strobe; packets_written=1.
- 40 continuous words without in_last, size=16, write_ready toggling as buffers drain -> buffers released at counts 16, 16, 8 (last via in_last on word 40); activate alternates 01, 10, 01; in_ready low during every RELEASE/IDLE gap.
- IDLE_TIMEOUT=10, send 3 words then stall in_valid -> release on the 10th idle cycle, packets_written increments; with zero words sent, no release ever occurs.
- in_last on the 16th word with size=16 -> exactly one release; packets_written +1, not +2.
- write_ready=00 held for 50 cycles with in_valid high -> in_ready=0 and write_activate=00 throughout; write_ready=10 then claims buffer 1.
- Assert rst mid-packet after 7 words -> write_activate=00, write_strobe=0, in_ready=0 in the same cycle (async); after deassert, normal claim resumes with buffer 0 preferred.
